mmio_console: RTL and testbench

Parametrised memory-mapped console/exit controller for the srv32 simulation environment. It sits on the core's data-memory write and read ports beside the data RAM and replaces fixed PUTC/EXIT address decoding with a synthesizable block. The block provides multiple character channels, a buffered TX FIFO with backpressure, an exit register that waits for the FIFO to drain, a status register, and an optional PC-stall watchdog.

---
 rtl/mmio_console_if.sv | 24 ++
 rtl/mmio_console.sv | 88 ++++++++
 tb/tb_mmio_console.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_console_if.sv
// mmio_console_if: core data-memory write/read ports and the TX character stream of mmio_console.
interface mmio_console_if;
    logic        wready;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wstall;
    logic        rready;
    logic [31:0] raddr;
    logic        rresp;
    logic [31:0] rdata;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  tx_chan;
    logic [7:0]  tx_data;
    modport master (
        output wready, waddr, wdata, wstrb, rready, raddr, tx_ready,
        input  wstall, rresp, rdata, tx_valid, tx_chan, tx_data
    );
    modport slave (
        input  wready, waddr, wdata, wstrb, rready, raddr, tx_ready,
        output wstall, rresp, rdata, tx_valid, tx_chan, tx_data
    );
endinterface

// File: rtl/mmio_console.sv
// mmio_console: PUTC channels into a TX FIFO, EXIT and STATUS registers on the srv32 data bus.
// Defining MMIO_WATCHDOG_EN builds the PC-stall watchdog; otherwise timeout is tied low.
module mmio_console #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          NCH       = 2,
    parameter int          DEPTH     = 16,
    parameter int          TIMEOUT   = 100
) (
    input  logic                 clk,
    input  logic                 resetb,
    mmio_console_if.slave        bus,
    output logic                 exit_valid,
    output logic [31:0]          exit_code,
    output logic                 exit_done,
    input  logic [31:0]          pc,
    output logic                 timeout
);
    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT = DEPTH[CW-1:0];
    localparam logic [31:0]     PUTC_END = 32'(4 * NCH);
    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   woff, roff, status;
    logic          full, empty, putc_hit, push, pop, exit_wr;
    assign woff     = bus.waddr - BASE_ADDR;
    assign roff     = bus.raddr - BASE_ADDR;
    assign putc_hit = woff[1:0] == 2'b00 && woff < PUTC_END;
    assign full     = count == FULL_CNT;
    assign empty    = count == '0;
    // full is judged before any same-cycle pop, so a full FIFO always refuses
    assign push     = bus.wready && putc_hit && bus.wstrb[0] && !full;
    assign pop      = !empty && bus.tx_ready;
    assign exit_wr  = bus.wready && woff == 32'h40 && |bus.wstrb && !exit_valid;
    assign bus.wstall   = bus.wready && putc_hit && full;
    assign bus.tx_valid = !empty;
    assign {bus.tx_chan, bus.tx_data} = mem[rd_ptr];
    assign exit_done    = exit_valid && empty;
    assign status       = {12'b0, timeout, exit_valid, empty, full, 16'(count)};
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) mem[wr_ptr] <= {woff[5:2], bus.wdata[7:0]};
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            exit_valid <= 1'b0;
            exit_code  <= '0;
            bus.rresp  <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            if (exit_wr) exit_valid <= 1'b1;
            if (exit_wr) exit_code <= bus.wdata;
            bus.rresp <= bus.rready;
            bus.rdata <= bus.rready && roff == 32'h44 ? status : '0;
        end
    end
`ifdef MMIO_WATCHDOG_EN
    logic [31:0] pc_q;
    logic [15:0] wd_cnt, wd_next;
    assign wd_next = pc != pc_q ? '0 : wd_cnt == 16'hffff ? wd_cnt : wd_cnt + 16'd1;
    // flag is set on the edge the counter reaches TIMEOUT, so it is visible with that count
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            pc_q    <= '0;
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            pc_q   <= pc;
            wd_cnt <= wd_next;
            if (wd_next == 16'(TIMEOUT)) timeout <= 1'b1;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_console.sv
// tb_mmio_console: table vectors, directed corner sequences and random traffic against a queue-based model.
module tb_mmio_console;
    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam int          NCH     = 2;
    localparam int          DEPTH   = 4;
    localparam int          TIMEOUT = 100;
`ifdef MMIO_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic [31:0] pc = '0;
    logic        exit_valid, exit_done, timeout;
    logic [31:0] exit_code;
    mmio_console_if bus();
    mmio_console #(.BASE_ADDR(BASE), .NCH(NCH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetb(resetb), .bus(bus), .exit_valid(exit_valid), .exit_code(exit_code),
        .exit_done(exit_done), .pc(pc), .timeout(timeout)
    );
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;
    logic [11:0] q[$];
    bit          m_ev, m_to, m_rresp;
    logic [31:0] m_ec, m_rdata, m_pc_prev;
    int          m_run;
    typedef struct {
        logic [31:0] off;
        logic [3:0]  strb;
        logic [7:0]  data;
        bit          stall;
        int          cnt;
    } vec_t;
    vec_t        tbl[12];
    logic [11:0] drain[4];
    logic [31:0] offs[8];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic bit putc_hit(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return o[1:0] == 2'b00 && o < 4 * NCH;
    endfunction
    task automatic idle();
        bus.wready = 0; bus.waddr = '0; bus.wdata = '0; bus.wstrb = '0;
        bus.rready = 0; bus.raddr = '0; bus.tx_ready = 0;
    endtask
    task automatic model_reset();
        q.delete();
        m_ev = 0; m_to = 0; m_rresp = 0; m_ec = '0; m_rdata = '0; m_pc_prev = '0; m_run = 0;
    endtask
    // one clock: wstall checked before the edge, model advanced at the edge, outputs checked after
    task automatic step();
        logic [31:0] o, st;
        bit dpop, dpush;
        @(negedge clk);
        chk("wstall", bus.wstall, bus.wready && putc_hit(bus.waddr) && q.size() == DEPTH);
        @(posedge clk);
        o = bus.waddr - BASE;
        st = {12'b0, WD && m_to, m_ev, q.size() == 0, q.size() == DEPTH, 16'(q.size())};
        m_rresp = bus.rready;
        m_rdata = (bus.rready && bus.raddr - BASE == 32'h44) ? st : '0;
        dpop  = q.size() > 0 && bus.tx_ready;
        dpush = bus.wready && putc_hit(bus.waddr) && bus.wstrb[0] && q.size() < DEPTH;
        if (!m_ev && bus.wready && o == 32'h40 && bus.wstrb != 0) begin
            m_ev = 1; m_ec = bus.wdata;
        end
        if (dpop) void'(q.pop_front());
        if (dpush) q.push_back({o[5:2], bus.wdata[7:0]});
        m_run = (pc == m_pc_prev) ? m_run + 1 : 0;
        m_pc_prev = pc;
        if (m_run >= TIMEOUT) m_to = 1;
        #1;
        chk("tx_valid", bus.tx_valid, q.size() > 0);
        if (q.size() > 0) chk("tx_head", {bus.tx_chan, bus.tx_data}, q[0]);
        chk("exit_valid", exit_valid, m_ev);
        chk("exit_code", exit_code, m_ec);
        chk("exit_done", exit_done, m_ev && q.size() == 0);
        chk("rresp", bus.rresp, m_rresp);
        chk("rdata", bus.rdata, m_rdata);
        chk("timeout", timeout, WD && m_to);
    endtask
    task automatic do_reset();
        idle();
        bus.wready = 1; bus.waddr = BASE;
        resetb = 0;
        model_reset();
        #1;
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_chan", bus.tx_chan, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_exit_valid", exit_valid, 0);
        chk("rst_exit_code", exit_code, 0);
        chk("rst_exit_done", exit_done, 0);
        chk("rst_rresp", bus.rresp, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_wstall", bus.wstall, 0);
        @(posedge clk);
        #1;
        resetb = 1;
        idle();
    endtask
    task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] strb);
        bus.wready = 1; bus.waddr = BASE + off; bus.wdata = data; bus.wstrb = strb;
        step();
        bus.wready = 0; bus.wstrb = '0;
    endtask
    task automatic rd_status();
        bus.rready = 1; bus.raddr = BASE + 32'h44;
        step();
        bus.rready = 0;
    endtask
    initial begin
        tbl = '{
            '{32'h000, 4'h1, 8'h41, 1'b0, 1}, '{32'h004, 4'hF, 8'h42, 1'b0, 2},
            '{32'h004, 4'h2, 8'h43, 1'b0, 2}, '{32'h020, 4'hF, 8'h44, 1'b0, 2},
            '{32'h008, 4'h1, 8'h45, 1'b0, 2}, '{32'h002, 4'h1, 8'h46, 1'b0, 2},
            '{32'h100, 4'h1, 8'h47, 1'b0, 2}, '{32'h000, 4'h1, 8'h48, 1'b0, 3},
            '{32'h004, 4'h1, 8'h49, 1'b0, 4}, '{32'h000, 4'h1, 8'h4A, 1'b1, 4},
            '{32'h044, 4'h1, 8'h4B, 1'b0, 4}, '{32'h004, 4'h2, 8'h4C, 1'b1, 4}
        };
        drain = '{12'h041, 12'h142, 12'h048, 12'h149};
        offs  = '{32'h00, 32'h04, 32'h08, 32'h40, 32'h44, 32'h20, 32'h02, 32'h00};
        idle();
        do_reset();
        rd_status();
        chk("status_after_reset", bus.rdata, 32'h0002_0000);
        // decode and backpressure table, tx sink held off
        for (int i = 0; i < 12; i++) begin
            bus.wready = 1; bus.waddr = BASE + tbl[i].off; bus.wdata = {24'h0, tbl[i].data};
            bus.wstrb = tbl[i].strb;
            #2;
            chk($sformatf("tbl%0d_stall", i), bus.wstall, tbl[i].stall);
            step();
            bus.wready = 0; bus.wstrb = '0;
            rd_status();
            chk($sformatf("tbl%0d_count", i), bus.rdata[15:0], tbl[i].cnt);
            chk($sformatf("tbl%0d_full", i), bus.rdata[16], tbl[i].cnt == DEPTH);
        end
        bus.tx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), {bus.tx_chan, bus.tx_data}, drain[i]);
            step();
        end
        chk("drain_empty", bus.tx_valid, 0);
        // two channels streamed straight through
        do_reset();
        bus.tx_ready = 1;
        wr(32'h00, 32'h41, 4'h1);
        chk("seq_head0", {bus.tx_chan, bus.tx_data}, 12'h041);
        wr(32'h04, 32'h42, 4'h1);
        chk("seq_head1", {bus.tx_chan, bus.tx_data}, 12'h142);
        step();
        chk("seq_empty", bus.tx_valid, 0);
        // fifth write held until a pop frees a slot
        do_reset();
        for (int i = 1; i <= 4; i++) wr(32'h00, i, 4'h1);
        bus.wready = 1; bus.waddr = BASE; bus.wdata = 32'h5; bus.wstrb = 4'h1;
        #2;
        chk("bp_stall_full", bus.wstall, 1);
        step();
        bus.tx_ready = 1;
        #2;
        chk("bp_stall_pop", bus.wstall, 1);
        step();
        bus.tx_ready = 0;
        #2;
        chk("bp_stall_free", bus.wstall, 0);
        step();
        bus.wready = 0;
        rd_status();
        chk("bp_status", bus.rdata, 32'h0001_0004);
        chk("bp_head", bus.tx_data, 8'h02);
        // exit waits for the FIFO to drain
        do_reset();
        for (int i = 0; i < 3; i++) wr(32'h04, 32'h60 + i, 4'h1);
        bus.tx_ready = 1;
        wr(32'h40, 32'h7, 4'h8);
        chk("exit_set", exit_valid, 1);
        chk("exit_not_done", exit_done, 0);
        wr(32'h40, 32'h9, 4'hF);
        chk("exit_code_kept", exit_code, 32'h7);
        step();
        chk("exit_done", exit_done, 1);
        bus.tx_ready = 0;
        wr(32'h00, 32'h55, 4'h1);
        chk("putc_after_exit", bus.tx_valid, 1);
        chk("exit_done_refill", exit_done, 0);
        // watchdog, constant pc
        do_reset();
        pc = 32'h100;
        for (int i = 1; i <= TIMEOUT + 1; i++) begin
            step();
            if (i == TIMEOUT) chk("wd_early", timeout, 0);
            if (i == TIMEOUT + 1) chk("wd_fire", timeout, WD);
        end
        // watchdog, pc change at cycle 50
        do_reset();
        pc = 32'h200;
        for (int i = 1; i <= 150; i++) begin
            step();
            if (i == 49) pc = 32'h204;
            if (i == 149) chk("wd_restart_early", timeout, 0);
            if (i == 150) chk("wd_restart_fire", timeout, WD);
        end
        // reset with queued data and exit set
        do_reset();
        for (int i = 0; i < 3; i++) wr(32'h00, 32'h70 + i, 4'h1);
        wr(32'h40, 32'h3, 4'h1);
        do_reset();
        rd_status();
        chk("status_mid_reset", bus.rdata, 32'h0002_0000);
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            bus.wready = $urandom_range(0, 1);
            bus.waddr = BASE + offs[$urandom_range(0, 7)];
            if ($urandom_range(0, 15) == 0) bus.waddr = $urandom;
            bus.wdata = $urandom;
            bus.wstrb = 4'($urandom);
            bus.rready = $urandom_range(0, 1);
            bus.raddr = BASE + offs[$urandom_range(0, 7)];
            bus.tx_ready = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 63) == 0) pc = $urandom_range(0, 7);
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
